alu_operand_buffer: RTL and testbench

ALU_OPERAND_BUFFER -- requirements
Module: alu_operand_buffer

---
 rtl/alu_operand_buffer_if.sv | 29 ++
 rtl/alu_operand_buffer.sv | 86 ++++++++
 tb/tb_alu_operand_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_buffer_if.sv
// Operand-pair handshake bundle between decode/regfile and the ALU, plus flush and occupancy.
// slave = buffer view, master = upstream/downstream driver view.
interface alu_operand_buffer_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [OPW-1:0]   out_op;
  logic [1:0]       occ;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, occ
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, occ
  );
endinterface

// File: rtl/alu_operand_buffer.sv
// 2-entry operand FIFO feeding the ALU; 1-cycle latency, no bypass.
// in_ready comes from registered occupancy only, so out_ready never reaches it combinationally.
module alu_operand_buffer #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_buffer_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } entry_t;

  logic [1:0] occ_q, occ_d;
  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  entry_t     in_entry;
  logic       enq;
  logic       deq;

  assign in_entry = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};

  assign bus.in_ready  = (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.occ       = occ_q;

  assign enq = bus.in_valid && bus.in_ready;
  assign deq = bus.out_valid && bus.out_ready;

  // Stale slot contents stay internal: outputs are forced to zero when empty.
  assign bus.out_a  = bus.out_valid ? slot0_q.a  : '0;
  assign bus.out_b  = bus.out_valid ? slot0_q.b  : '0;
  assign bus.out_op = bus.out_valid ? slot0_q.op : '0;

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (bus.flush) begin
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (enq) begin
            slot0_d = in_entry;
            occ_d   = 2'd1;
          end
        end
        2'd1: begin
          if (enq && deq) begin
            slot0_d = in_entry;
          end else if (enq) begin
            slot1_d = in_entry;
            occ_d   = 2'd2;
          end else if (deq) begin
            occ_d = 2'd0;
          end
        end
        2'd2: begin
          if (deq) begin
            slot0_d = slot1_q;
            occ_d   = 2'd1;
          end
        end
        default: occ_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_buffer.sv
// Directed vector table plus async-reset, flush and random-stream sequences for alu_operand_buffer.
module tb_alu_operand_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_operand_buffer_if #(.WIDTH(32), .OPW(3)) bus ();

  alu_operand_buffer #(.WIDTH(32), .OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [1:0]  e_occ;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [2:0]  e_op;
  } vec_t;

  localparam int NVEC = 23;
  localparam int NRAND = 10000;

  vec_t vec [NVEC];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] e_occ, input logic e_ov,
                           input logic e_ir, input logic [31:0] e_a, input logic [31:0] e_b,
                           input logic [2:0] e_op);
    chk({tag, ".occ"},       {65'd0, bus.occ},       {65'd0, e_occ});
    chk({tag, ".out_valid"}, {66'd0, bus.out_valid}, {66'd0, e_ov});
    chk({tag, ".in_ready"},  {66'd0, bus.in_ready},  {66'd0, e_ir});
    chk({tag, ".out_a"},     {35'd0, bus.out_a},     {35'd0, e_a});
    chk({tag, ".out_b"},     {35'd0, bus.out_b},     {35'd0, e_b});
    chk({tag, ".out_op"},    {64'd0, bus.out_op},    {64'd0, e_op});
  endtask

  initial begin
    logic [66:0] model_q [$];
    logic [66:0] cur;
    logic [66:0] got;
    logic        have;
    logic        hold;
    logic        enq;
    logic        deq;
    int          sent;
    int          recv;
    int          cyc;

    //          iv    ordy  fl    a              b              op       occ    ov    ir    e_a            e_b            e_op
    vec[0]  = '{1'b1, 1'b1, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd0,   2'd1, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 32'h1,        32'h11,       3'd1,   2'd1, 1'b1, 1'b1, 32'h1,        32'h11,       3'd1};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h2,        32'h22,       3'd2,   2'd2, 1'b1, 1'b0, 32'h1,        32'h11,       3'd1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h3,        32'h33,       3'd3,   2'd2, 1'b1, 1'b0, 32'h1,        32'h11,       3'd1};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 32'h3,        32'h33,       3'd3,   2'd1, 1'b1, 1'b1, 32'h2,        32'h22,       3'd2};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[7]  = '{1'b1, 1'b0, 1'b0, 32'hAAAA0000, 32'h1,        3'd5,   2'd1, 1'b1, 1'b1, 32'hAAAA0000, 32'h1,        3'd5};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 32'h5555FFFF, 32'h2,        3'd6,   2'd1, 1'b1, 1'b1, 32'h5555FFFF, 32'h2,        3'd6};
    vec[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[10] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7,   2'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7};
    vec[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd1, 1'b1, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[13] = '{1'b1, 1'b0, 1'b0, 32'h10,       32'h100,      3'd1,   2'd1, 1'b1, 1'b1, 32'h10,       32'h100,      3'd1};
    vec[14] = '{1'b1, 1'b0, 1'b0, 32'h20,       32'h200,      3'd2,   2'd2, 1'b1, 1'b0, 32'h10,       32'h100,      3'd1};
    vec[15] = '{1'b1, 1'b1, 1'b0, 32'h30,       32'h300,      3'd3,   2'd1, 1'b1, 1'b1, 32'h20,       32'h200,      3'd2};
    vec[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[17] = '{1'b1, 1'b0, 1'b0, 32'h40,       32'h400,      3'd4,   2'd1, 1'b1, 1'b1, 32'h40,       32'h400,      3'd4};
    vec[18] = '{1'b1, 1'b0, 1'b0, 32'h50,       32'h500,      3'd5,   2'd2, 1'b1, 1'b0, 32'h40,       32'h400,      3'd4};
    vec[19] = '{1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 3'd7,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};
    vec[21] = '{1'b1, 1'b0, 1'b0, 32'h60,       32'h600,      3'd6,   2'd1, 1'b1, 1'b1, 32'h60,       32'h600,      3'd6};
    vec[22] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0,   2'd0, 1'b0, 1'b1, 32'h0,        32'h0,        3'd0};

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    #12;
    chk_state("reset", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      bus.in_valid  = vec[i].iv;
      bus.out_ready = vec[i].ordy;
      bus.flush     = vec[i].fl;
      bus.in_a      = vec[i].a;
      bus.in_b      = vec[i].b;
      bus.in_op     = vec[i].op;
      step();
      chk_state($sformatf("vec%0d", i), vec[i].e_occ, vec[i].e_ov, vec[i].e_ir,
                vec[i].e_a, vec[i].e_b, vec[i].e_op);
    end
    bus.flush = 1'b0;

    // Async reset while full: must clear between clock edges.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a = 32'h70; bus.in_b = 32'h700; bus.in_op = 3'd1;
    step();
    bus.in_a = 32'h80; bus.in_b = 32'h800; bus.in_op = 3'd2;
    step();
    chk_state("pre_arst", 2'd2, 1'b1, 1'b0, 32'h70, 32'h700, 3'd1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("arst", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 32'h90; bus.in_b = 32'h900; bus.in_op = 3'd3;
    step();
    chk_state("post_arst_enq", 2'd1, 1'b1, 1'b1, 32'h90, 32'h900, 3'd3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_state("post_arst_drain", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);

    // Random stream against a queue scoreboard.
    have = 1'b0;
    hold = 1'b0;
    sent = 0;
    recv = 0;
    cyc  = 0;
    cur  = '0;
    while (recv < NRAND && cyc < 60000) begin
      if (!have && sent < NRAND) begin
        cur  = {$urandom, $urandom, 3'($urandom)};
        have = 1'b1;
      end
      bus.in_valid  = have && (hold || ($urandom_range(0, 3) != 0));
      bus.in_a      = cur[66:35];
      bus.in_b      = cur[34:3];
      bus.in_op     = cur[2:0];
      bus.out_ready = ($urandom_range(0, 3) != 0);
      enq = bus.in_valid && bus.in_ready;
      deq = bus.out_valid && bus.out_ready;
      if (deq) begin
        got = {bus.out_a, bus.out_b, bus.out_op};
        if (model_q.size() == 0) begin
          chk("rand_underflow", 67'd1, 67'd0);
        end else begin
          chk($sformatf("rand_data%0d", recv), got, model_q.pop_front());
        end
        recv++;
      end
      if (enq) begin
        model_q.push_back(cur);
        have = 1'b0;
        hold = 1'b0;
        sent++;
      end else begin
        hold = bus.in_valid;
      end
      step();
      cyc++;
      chk("rand_occ", {65'd0, bus.occ}, 67'(model_q.size()));
    end
    chk("rand_received", 67'(recv), 67'(NRAND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
